// File: rtl/i2d_bus_arb_pkg.sv
// i2d_bus_arb_pkg: shared state encodings and constants for the fetch/load-store bus arbiter.
package i2d_bus_arb_pkg;
  typedef enum logic [1:0] {
    I2D_ARB_IDLE = 2'd0,
    I2D_ARB_IF   = 2'd1,
    I2D_ARB_MEM  = 2'd2
  } arb_state_t;
  localparam logic [3:0] I2D_WB_SEL_ALL = 4'hF;
  localparam int I2D_DEF_TIMEOUT = 255;
endpackage

// File: rtl/i2d_arb_timer.sv
// i2d_arb_timer: cycle counter bounding how long a granted bus cycle may wait.
//   clk, rst (sync, active-low); i_clr clears, i_en counts one cycle;
//   o_expired is high while the count equals TIMEOUT-1.
module i2d_arb_timer
  import i2d_bus_arb_pkg::*;
#(
  parameter int TIMEOUT = I2D_DEF_TIMEOUT,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (!rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_expired = r_cnt == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/i2d_bus_arb.sv
// i2d_bus_arb: shares one Wishbone classic bus between the fetch port and the load/store port.
//   clk, rst (sync, active-low)
//   if_*  : read-only fetch requester (req/adr in, dat/ack/err out)
//   mem_* : load/store requester (req/we/sel/adr/wdat in, rdat/ack/err out)
//   *_o/*_i : Wishbone master side; gnt_mem flags load/store ownership
module i2d_bus_arb
  import i2d_bus_arb_pkg::*;
#(
  parameter int TIMEOUT = I2D_DEF_TIMEOUT,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  output logic [31:0] if_dat,
  output logic        if_ack,
  output logic        if_err,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_adr,
  input  logic [31:0] mem_wdat,
  output logic [31:0] mem_rdat,
  output logic        mem_ack,
  output logic        mem_err,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        rty_i,
  input  logic        err_i,
  output logic        gnt_mem
);
  arb_state_t  r_state, w_next;
  logic        r_we, r_last_mem;
  logic [3:0]  r_sel;
  logic [31:0] r_adr, r_dat;
  logic        w_bus, w_if, w_mem, w_grant_mem, w_grant_if;
  logic        w_expired, w_fail, w_done, w_unused;
  // A retrying slave simply keeps the cycle open, so rty_i needs no logic of its own.
  assign w_unused = rty_i;
  assign w_bus = r_state != I2D_ARB_IDLE;
  assign w_if = r_state == I2D_ARB_IF;
  assign w_mem = r_state == I2D_ARB_MEM;
  // Load/store wins ties unless it won the previous grant, so the ports alternate.
  assign w_grant_mem = !w_bus && mem_req && (!if_req || !r_last_mem);
  assign w_grant_if = !w_bus && if_req && !w_grant_mem;
  // An ack arriving in the expiry cycle still completes normally.
  assign w_fail = err_i || (!ack_i && w_expired);
  assign w_done = ack_i || w_fail;
  always_comb begin
    w_next = r_state;
    if (w_grant_mem) w_next = I2D_ARB_MEM;
    else if (w_grant_if) w_next = I2D_ARB_IF;
    else if (w_bus && w_done) w_next = I2D_ARB_IDLE;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= I2D_ARB_IDLE;
      r_we <= 1'b0;
      r_sel <= '0;
      r_adr <= '0;
      r_dat <= '0;
      r_last_mem <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_mem) begin
        r_we <= mem_we;
        r_sel <= mem_sel;
        r_adr <= mem_adr;
        r_dat <= mem_wdat;
        r_last_mem <= 1'b1;
      end else if (w_grant_if) begin
        r_we <= 1'b0;
        r_sel <= I2D_WB_SEL_ALL;
        r_adr <= if_adr;
        r_dat <= '0;
        r_last_mem <= 1'b0;
      end
    end
  i2d_arb_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .i_clr(!w_bus),
    .i_en(w_bus && !ack_i && !err_i),
    .o_expired(w_expired)
  );
  assign cyc_o = w_bus;
  assign stb_o = w_bus;
  assign we_o = r_we;
  assign sel_o = r_sel;
  assign adr_o = r_adr;
  assign dat_o = r_dat;
  assign gnt_mem = w_mem;
  assign if_ack = w_if && ack_i && !err_i;
  assign if_err = w_if && w_fail;
  assign if_dat = if_ack ? dat_i : '0;
  assign mem_ack = w_mem && ack_i && !err_i;
  assign mem_err = w_mem && w_fail;
  assign mem_rdat = mem_ack ? dat_i : '0;
endmodule

// File: tb/tb_i2d_bus_arb.sv
// tb_i2d_bus_arb: self-checking bench for i2d_bus_arb (TIMEOUT=8).
module tb_i2d_bus_arb;
  localparam int TMO = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_adr = '0;
  logic [31:0] if_dat;
  logic        if_ack, if_err;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_adr = '0, mem_wdat = '0;
  logic [31:0] mem_rdat;
  logic        mem_ack, mem_err;
  logic        cyc_o, stb_o, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0, rty_i = 1'b0, err_i = 1'b0;
  logic        gnt_mem;
  int total = 0;
  int bad = 0;

  i2d_bus_arb #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_dat(if_dat), .if_ack(if_ack), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_adr(mem_adr),
    .mem_wdat(mem_wdat), .mem_rdat(mem_rdat), .mem_ack(mem_ack), .mem_err(mem_err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .rty_i(rty_i), .err_i(err_i), .gnt_mem(gnt_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          wt;
    bit          rty;
    bit          ack;
    bit          err;
    logic [31:0] e_dato;
    logic [3:0]  e_sel;
    bit          e_we;
    bit          e_ack;
    bit          e_err;
    logic [31:0] e_rdat;
  } vec_t;

  typedef struct {
    bit          m;
    logic [31:0] adr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] dato;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic do_xfer(input vec_t v);
    exp_t e;
    int n;
    @(negedge clk);
    if (v.m) begin
      mem_req = 1'b1; mem_we = v.we; mem_sel = v.sel; mem_adr = v.adr; mem_wdat = v.wdat;
    end else begin
      if_req = 1'b1; if_adr = v.adr;
    end
    q.push_back('{v.m, v.adr, v.e_we, v.e_sel, v.e_dato});
    n = 0;
    do begin @(negedge clk); n++; end while (!cyc_o && n < 20);
    chk("grant_latency", n, 1);
    if (!cyc_o) begin
      if_req = 1'b0; mem_req = 1'b0;
      return;
    end
    e = q.pop_front();
    chk("adr_o", adr_o, e.adr);
    chk("we_o", {31'd0, we_o}, {31'd0, e.we});
    chk("sel_o", {28'd0, sel_o}, {28'd0, e.sel});
    chk("dat_o", dat_o, e.dato);
    chk("gnt_mem", {31'd0, gnt_mem}, {31'd0, e.m});
    for (int i = 0; i < v.wt; i++) begin
      rty_i = v.rty;
      #2;
      chk("wait_no_resp", {28'd0, if_ack, if_err, mem_ack, mem_err}, 32'd0);
      chk("wait_stable", {adr_o[27:0], sel_o}, {e.adr[27:0], e.sel});
      chk("wait_stb", {31'd0, stb_o && cyc_o}, 32'd1);
      @(negedge clk);
    end
    rty_i = 1'b0; ack_i = v.ack; err_i = v.err; dat_i = v.rdat;
    #2;
    chk("resp_ack", {31'd0, v.m ? mem_ack : if_ack}, {31'd0, v.e_ack});
    chk("resp_err", {31'd0, v.m ? mem_err : if_err}, {31'd0, v.e_err});
    chk("resp_dat", v.m ? mem_rdat : if_dat, v.e_rdat);
    chk("other_quiet", {30'd0, v.m ? {if_ack, if_err} : {mem_ack, mem_err}}, 32'd0);
    @(negedge clk);
    if_req = 1'b0; mem_req = 1'b0; ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    #1;
    chk("after_cyc", {30'd0, cyc_o, stb_o}, 32'd0);
    chk("after_quiet", {28'd0, if_ack, if_err, mem_ack, mem_err}, 32'd0);
  endtask

  vec_t vt[8];

  initial begin
    int n;
    bit gq[$];
    bit g;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit gq[$];
    bit g;
    // m we sel adr wdat rdat wt rty ack err | e_dato e_sel e_we e_ack e_err e_rdat
    vt[0] = '{0, 0, 4'h0, 32'h100,  32'h0,    32'hDEADBEEF, 0,   0, 1, 0, 32'h0,    4'hF, 0, 1, 0, 32'hDEADBEEF};
    vt[1] = '{1, 0, 4'hF, 32'h3000, 32'h55,   32'hCAFEF00D, 2,   0, 1, 0, 32'h55,   4'hF, 0, 1, 0, 32'hCAFEF00D};
    vt[2] = '{1, 1, 4'h3, 32'h2000, 32'h1234, 32'hAAAA0000, 5,   1, 1, 0, 32'h1234, 4'h3, 1, 1, 0, 32'hAAAA0000};
    vt[3] = '{1, 0, 4'hC, 32'h4004, 32'h0,    32'h77777777, 1,   0, 1, 1, 32'h0,    4'hC, 0, 0, 1, 32'h0};
    vt[4] = '{0, 0, 4'h0, 32'h104,  32'h0,    32'h12345678, 0,   0, 0, 1, 32'h0,    4'hF, 0, 0, 1, 32'h0};
    vt[5] = '{0, 0, 4'h0, 32'h108,  32'h0,    32'h0,        TMO-1, 0, 0, 0, 32'h0,  4'hF, 0, 0, 1, 32'h0};
    vt[6] = '{1, 1, 4'h1, 32'h5000, 32'h99,   32'h0,        TMO-1, 1, 0, 0, 32'h99, 4'h1, 1, 0, 1, 32'h0};
    vt[7] = '{0, 0, 4'h0, 32'h10C,  32'h0,    32'h0BADCAFE, TMO-2, 0, 1, 0, 32'h0,  4'hF, 0, 1, 0, 32'h0BADCAFE};

    repeat (2) @(negedge clk);
    chk("rst_ctrl", {29'd0, cyc_o, stb_o, we_o}, 32'd0);
    chk("rst_sel", {28'd0, sel_o}, 32'd0);
    chk("rst_adr", adr_o, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_gnt", {31'd0, gnt_mem}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) do_xfer(vt[i]);

    // Contention after a fresh reset: load/store first, then strict alternation.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b1; if_adr = 32'h400;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_adr = 32'h800; mem_wdat = 32'h0;
    gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!cyc_o && n < 10);
      chk("cont_latency", n, 1);
      g = gq.pop_front();
      chk("cont_gnt", {31'd0, gnt_mem}, {31'd0, g});
      chk("cont_adr", adr_o, g ? 32'h800 : 32'h400);
      ack_i = 1'b1; dat_i = 32'hA0 + k;
      #2;
      chk("cont_ack", {30'd0, mem_ack, if_ack}, g ? 32'd2 : 32'd1);
      chk("cont_dat", g ? mem_rdat : if_dat, 32'hA0 + k);
      @(negedge clk);
      ack_i = 1'b0; dat_i = '0;
      #1;
      chk("cont_idle_gap", {31'd0, cyc_o}, 32'd0);
    end

    // Both still requesting, last winner was fetch: load/store is granted, then reset hits mid-cycle.
    @(negedge clk);
    chk("mid_gnt", {31'd0, gnt_mem}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_bus", {29'd0, cyc_o, stb_o, gnt_mem}, 32'd0);
    ack_i = 1'b1; dat_i = 32'h11111111;
    #2;
    chk("mid_rst_quiet", {28'd0, if_ack, if_err, mem_ack, mem_err}, 32'd0);
    @(negedge clk);
    ack_i = 1'b0; dat_i = '0; mem_req = 1'b0; rst = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cyc_o && n < 10);
    chk("post_rst_latency", n, 1);
    chk("post_rst_gnt", {31'd0, gnt_mem}, 32'd0);
    chk("post_rst_adr", adr_o, 32'h400);
    ack_i = 1'b1; dat_i = 32'h600DF00D;
    #2;
    chk("post_rst_ack", {31'd0, if_ack}, 32'd1);
    chk("post_rst_dat", if_dat, 32'h600DF00D);
    @(negedge clk);
    ack_i = 1'b0; dat_i = '0; if_req = 1'b0;
    #1;
    chk("post_rst_idle", {31'd0, cyc_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
